// File: rtl/ceespu_sprite_engine.sv
// Multi-sprite overlay for the ceespu GPU: bus-written sprite registers and 1-bpp bitmaps,
// per-scanline row prefetch into line registers, and a registered per-pixel priority/collision path.
module ceespu_sprite_engine #(
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_WIDTH  = 24,
    parameter int SPRITE_HEIGHT = 21,
    parameter int X_WIDTH       = 11,
    parameter int Y_WIDTH       = 10,
    parameter int COLOR_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [X_WIDTH-1:0]     x,
    input  logic [Y_WIDTH-1:0]     y,
    input  logic                   new_x,
    input  logic                   new_y,
    input  logic                   sys_we,
    input  logic [ADDR_WIDTH-1:0]  sys_addr,
    input  logic [31:0]            sys_data,
    output logic                   pixel_valid,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic [((NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1)-1:0] pixel_id,
    output logic                   collision,
    output logic                   fetch_busy
);

    localparam int IDW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int RW  = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
    localparam int BW  = (SPRITE_WIDTH > 1) ? $clog2(SPRITE_WIDTH) : 1;
    localparam logic [X_WIDTH:0] SW_X    = (X_WIDTH + 1)'(SPRITE_WIDTH);
    localparam logic [Y_WIDTH:0] SH_Y    = (Y_WIDTH + 1)'(SPRITE_HEIGHT);
    localparam logic [BW-1:0]    BIT_MSB = BW'(SPRITE_WIDTH - 1);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t                   state_q, state_d;
    logic [IDW-1:0]           k_q, k_d;
    logic [Y_WIDTH-1:0]       ly_q, ly_d;

    logic [X_WIDTH-1:0]       sx_q  [NUM_SPRITES];
    logic [X_WIDTH-1:0]       sx_d  [NUM_SPRITES];
    logic [Y_WIDTH-1:0]       sy_q  [NUM_SPRITES];
    logic [Y_WIDTH-1:0]       sy_d  [NUM_SPRITES];
    logic [COLOR_WIDTH-1:0]   col_q [NUM_SPRITES];
    logic [COLOR_WIDTH-1:0]   col_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]   en_q, en_d;
    logic [SPRITE_WIDTH-1:0]  line_q [NUM_SPRITES];
    logic [SPRITE_WIDTH-1:0]  line_d [NUM_SPRITES];
    logic [SPRITE_WIDTH-1:0]  mem_q  [NUM_SPRITES][SPRITE_HEIGHT];

    logic                     valid_q, valid_d;
    logic [COLOR_WIDTH-1:0]   color_q, color_d;
    logic [IDW-1:0]           id_q, id_d;
    logic                     coll_q, coll_d;

    // Bus decode
    logic [31:0]              addr_w, reg_slot, bm_off, bm_slot, bm_row;
    logic [1:0]               reg_field;
    logic                     reg_hit, clr_coll, bm_we;
    logic [IDW-1:0]           bm_s;
    logic [RW-1:0]            bm_r;
    logic                     unused_data;

    assign unused_data = ^sys_data;

    always_comb begin
        addr_w    = 32'(sys_addr);
        reg_slot  = addr_w >> 2;
        reg_field = addr_w[1:0];
        bm_off    = addr_w - 32'd128;
        bm_slot   = bm_off >> 5;
        bm_row    = bm_off & 32'h1F;
        reg_hit   = sys_we && (addr_w < 32'd128);
        clr_coll  = sys_we && (addr_w == 32'h7F);
        bm_we     = sys_we && (addr_w >= 32'd128) && (bm_slot < NUM_SPRITES)
                    && (bm_row < SPRITE_HEIGHT);
        bm_s      = IDW'(bm_slot);
        bm_r      = RW'(bm_row);
    end

    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        col_d = col_q;
        en_d  = en_q;
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            if (reg_hit && (reg_slot == s)) begin
                case (reg_field)
                    2'd0: sx_d[s] = sys_data[X_WIDTH-1:0];
                    2'd1: sy_d[s] = sys_data[Y_WIDTH-1:0];
                    2'd2: begin
                        en_d[s]  = sys_data[31];
                        col_d[s] = sys_data[COLOR_WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Prefetch FSM: one sprite row per cycle into the line registers
    logic [Y_WIDTH:0]         dy;
    logic                     row_hit;
    logic [SPRITE_WIDTH-1:0]  row_data;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        ly_d     = ly_q;
        line_d   = line_q;
        dy       = {1'b0, ly_q} - {1'b0, sy_q[k_q]};
        row_hit  = en_q[k_q] && !dy[Y_WIDTH] && (dy < SH_Y);
        row_data = mem_q[k_q][dy[RW-1:0]];
        case (state_q)
            IDLE: begin
                if (new_y) begin
                    ly_d    = y;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                line_d[k_q] = row_hit ? row_data : '0;
                if (new_y) begin
                    ly_d = y;
                    k_d  = '0;
                end else if (32'(k_q) == NUM_SPRITES - 1) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel compare: scanning upward, the first opaque sprite wins; any later one flags overlap
    logic [X_WIDTH:0]         dx;
    logic                     opaque, any_opaque, multi_opaque;
    logic [COLOR_WIDTH-1:0]   win_col;
    logic [IDW-1:0]           win_id;

    always_comb begin
        dx           = '0;
        opaque       = 1'b0;
        any_opaque   = 1'b0;
        multi_opaque = 1'b0;
        win_col      = '0;
        win_id       = '0;
        for (int unsigned s = 0; s < NUM_SPRITES; s++) begin
            dx     = {1'b0, x} - {1'b0, sx_q[s]};
            opaque = en_q[s] && !dx[X_WIDTH] && (dx < SW_X)
                     && line_q[s][BIT_MSB - dx[BW-1:0]];
            if (opaque) begin
                if (any_opaque) begin
                    multi_opaque = 1'b1;
                end else begin
                    win_col = col_q[s];
                    win_id  = IDW'(s);
                end
                any_opaque = 1'b1;
            end
        end

        valid_d = valid_q;
        color_d = color_q;
        id_d    = id_q;
        if (new_x) begin
            valid_d = any_opaque;
            color_d = win_col;
            id_d    = win_id;
        end

        coll_d = coll_q;
        if (clr_coll) coll_d = 1'b0;
        if (new_x && multi_opaque) coll_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            ly_q    <= '0;
            sx_q    <= '{default: '0};
            sy_q    <= '{default: '0};
            col_q   <= '{default: '0};
            en_q    <= '0;
            line_q  <= '{default: '0};
            valid_q <= 1'b0;
            color_q <= '0;
            id_q    <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ly_q    <= ly_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            col_q   <= col_d;
            en_q    <= en_d;
            line_q  <= line_d;
            valid_q <= valid_d;
            color_q <= color_d;
            id_q    <= id_d;
            coll_q  <= coll_d;
        end
    end

    // Bitmap RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (bm_we) mem_q[bm_s][bm_r] <= sys_data[SPRITE_WIDTH-1:0];
    end

    assign pixel_valid = valid_q;
    assign pixel_color = color_q;
    assign pixel_id    = id_q;
    assign collision   = coll_q;
    assign fetch_busy  = (state_q == FETCH);

endmodule

// File: tb/tb_ceespu_sprite_engine.sv
// Directed table-driven bench for ceespu_sprite_engine at default parameters.
module tb_ceespu_sprite_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [9:0]  y;
    logic        new_x, new_y, sys_we;
    logic [7:0]  sys_addr;
    logic [31:0] sys_data;
    logic        pixel_valid;
    logic [7:0]  pixel_color;
    logic [1:0]  pixel_id;
    logic        collision;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    ceespu_sprite_engine #(
        .NUM_SPRITES(4),
        .SPRITE_WIDTH(24),
        .SPRITE_HEIGHT(21),
        .X_WIDTH(11),
        .Y_WIDTH(10),
        .COLOR_WIDTH(8),
        .ADDR_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .x(x),
        .y(y),
        .new_x(new_x),
        .new_y(new_y),
        .sys_we(sys_we),
        .sys_addr(sys_addr),
        .sys_data(sys_data),
        .pixel_valid(pixel_valid),
        .pixel_color(pixel_color),
        .pixel_id(pixel_id),
        .collision(collision),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        nx;
        logic [10:0] xx;
        logic        ny;
        logic [9:0]  yy;
        logic        cb;
        logic        eb;
        logic        cp;
        logic        ev;
        logic [7:0]  ec;
        logic [1:0]  eid;
        logic        ecoll;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic rst, logic we, logic [7:0] a, logic [31:0] d,
                                logic nx, logic [10:0] xx, logic ny, logic [9:0] yy,
                                logic cb, logic eb, logic cp, logic ev,
                                logic [7:0] ec, logic [1:0] eid, logic ecoll);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = a; v.data = d;
        v.nx = nx; v.xx = xx; v.ny = ny; v.yy = yy;
        v.cb = cb; v.eb = eb; v.cp = cp; v.ev = ev;
        v.ec = ec; v.eid = eid; v.ecoll = ecoll;
        vq.push_back(v);
    endfunction

    function automatic void wr(logic [7:0] a, logic [31:0] d);
        add(0, 1, a, d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void px(logic [10:0] xx, logic ev, logic [7:0] ec, logic [1:0] eid,
                               logic ecoll);
        add(0, 0, 0, 0, 1, xx, 0, 0, 0, 0, 1, ev, ec, eid, ecoll);
    endfunction

    function automatic void hd(logic ev, logic [7:0] ec, logic [1:0] eid, logic ecoll);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ev, ec, eid, ecoll);
    endfunction

    function automatic void wt(logic eb);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, eb, 0, 0, 0, 0, 0);
    endfunction

    function automatic void fetch(logic [9:0] yy);
        add(0, 0, 0, 0, 0, 0, 1, yy, 1, 1, 0, 0, 0, 0, 0);
        wt(1); wt(1); wt(1); wt(0);
    endfunction

    task automatic cyc(logic rst, logic we, logic [7:0] a, logic [31:0] d,
                       logic nx, logic [10:0] xx, logic ny, logic [9:0] yy);
        reset = rst; sys_we = we; sys_addr = a; sys_data = d;
        new_x = nx; x = xx; new_y = ny; y = yy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_outputs", {27'b0, fetch_busy, pixel_valid, collision, pixel_id},
            32'd0);
        chk("reset_color", {24'b0, pixel_color}, 32'd0);

        for (int i = 0; i <= 100; i++) begin
            cyc(0, 0, 0, 0, 1, 11'(i), 0, 0);
            chk("empty_sweep", {29'b0, pixel_valid, collision, fetch_busy}, 32'd0);
        end

        // single sprite, edges of the horizontal span
        wr(8'h00, 32'd100); wr(8'h01, 32'd50); wr(8'h02, 32'h8000_003C); wr(8'h80, 32'hFF_FFFF);
        fetch(50);
        px(99, 0, 8'h00, 0, 0); px(100, 1, 8'h3C, 0, 0);
        px(123, 1, 8'h3C, 0, 0); px(124, 0, 8'h00, 0, 0);
        px(110, 1, 8'h3C, 0, 0); hd(1, 8'h3C, 0, 0);

        // overlap, priority, sticky collision and its clear
        wr(8'h08, 32'd100); wr(8'h09, 32'd50); wr(8'h0A, 32'h8000_0022); wr(8'hC0, 32'hFF_FFFF);
        wr(8'h02, 32'h8000_0011);
        fetch(50);
        px(105, 1, 8'h11, 0, 1);
        wr(8'h7F, 32'd0); hd(1, 8'h11, 0, 0);
        px(106, 1, 8'h11, 0, 1);
        add(0, 1, 8'h7F, 0, 1, 107, 0, 0, 0, 0, 1, 1, 8'h11, 0, 1);
        wr(8'h02, 32'h0000_0011); px(105, 1, 8'h22, 2, 1);
        wr(8'h7F, 32'd0); px(105, 1, 8'h22, 2, 0);
        wr(8'h0A, 32'h0000_0022); px(105, 0, 8'h00, 0, 0);

        // bit order and disable
        wr(8'h0C, 32'd200); wr(8'h0D, 32'd60); wr(8'h0E, 32'h8000_0055); wr(8'hE0, 32'h80_0001);
        fetch(60);
        px(200, 1, 8'h55, 3, 0); px(201, 0, 8'h00, 0, 0); px(222, 0, 8'h00, 0, 0);
        px(223, 1, 8'h55, 3, 0); px(224, 0, 8'h00, 0, 0);
        wr(8'h0E, 32'h0000_0055); px(200, 0, 8'h00, 0, 0);
        wr(8'h0E, 32'h8000_0055);

        // last row, out-of-range row write, out-of-range dy
        wr(8'hE1, 32'h40_0000); wr(8'hF4, 32'h00_0001); wr(8'hF5, 32'hFF_FFFF);
        fetch(80);
        px(223, 1, 8'h55, 3, 0); px(222, 0, 8'h00, 0, 0);
        fetch(81);
        px(223, 0, 8'h00, 0, 0);

        // new_y during FETCH restarts the sweep
        add(0, 0, 0, 0, 0, 0, 1, 60, 1, 1, 0, 0, 0, 0, 0);
        wt(1);
        add(0, 0, 0, 0, 0, 0, 1, 61, 1, 1, 0, 0, 0, 0, 0);
        wt(1); wt(1); wt(1); wt(0);
        px(201, 1, 8'h55, 3, 0); px(200, 0, 8'h00, 0, 0);

        // no wrap-around hits in x or y
        wr(8'h04, 32'd2040); wr(8'h05, 32'd0); wr(8'h06, 32'h8000_0077); wr(8'hA3, 32'hFF_FFFF);
        fetch(3);
        px(5, 0, 8'h00, 0, 0); px(2045, 1, 8'h77, 1, 0);
        wr(8'h04, 32'd0); wr(8'h05, 32'd1020); wr(8'hA7, 32'hFF_FFFF);
        fetch(3);
        px(5, 0, 8'h00, 0, 0);
        wr(8'h04, 32'd2030); wr(8'hA2, 32'hFF_FFFF);
        fetch(1022);
        px(2040, 1, 8'h77, 1, 0);

        // bitmap write in the same cycle as the fetch of that row returns the old row
        add(0, 0, 0, 0, 0, 0, 1, 1022, 1, 1, 0, 0, 0, 0, 0);
        wt(1);
        add(0, 1, 8'hA2, 32'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        wt(1); wt(0);
        px(2040, 1, 8'h77, 1, 0);
        fetch(1022);
        px(2040, 0, 8'h00, 0, 0);
        wr(8'hA2, 32'hFF_FFFF);
        fetch(1022);
        px(2040, 1, 8'h77, 1, 0);

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].rst, vq[i].we, vq[i].addr, vq[i].data,
                vq[i].nx, vq[i].xx, vq[i].ny, vq[i].yy);
            if (vq[i].cb) begin
                checks++;
                if (fetch_busy !== vq[i].eb) begin
                    errors++;
                    $display("FAIL vec%0d busy: got %b expected %b", i, fetch_busy, vq[i].eb);
                end
            end
            if (vq[i].cp) begin
                checks++;
                if ({pixel_valid, pixel_color, pixel_id, collision} !==
                    {vq[i].ev, vq[i].ec, vq[i].eid, vq[i].ecoll}) begin
                    errors++;
                    $display("FAIL vec%0d pixel: got v=%b c=%h id=%0d coll=%b expected v=%b c=%h id=%0d coll=%b",
                             i, pixel_valid, pixel_color, pixel_id, collision,
                             vq[i].ev, vq[i].ec, vq[i].eid, vq[i].ecoll);
                end
            end
        end

        // reset in the middle of a prefetch
        cyc(0, 0, 0, 0, 0, 0, 1, 1022);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("busy_before_reset", {31'b0, fetch_busy}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_mid_fetch", {20'b0, fetch_busy, pixel_valid, collision, pixel_id, pixel_color},
            32'd0);

        // sprite registers re-written, no prefetch yet: line registers must be empty
        cyc(0, 1, 8'h04, 32'd2030, 0, 0, 0, 0);
        cyc(0, 1, 8'h06, 32'h8000_0077, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2040, 0, 0);
        chk("line_cleared", {31'b0, pixel_valid}, 32'd0);

        // bitmap survives reset
        cyc(0, 1, 8'h05, 32'd1020, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1022);
        for (int n = 0; n < 10 && fetch_busy; n++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fetch_done", {31'b0, fetch_busy}, 32'd0);
        cyc(0, 0, 0, 0, 1, 2040, 0, 0);
        chk("bitmap_kept", {21'b0, pixel_valid, pixel_color, pixel_id},
            {21'b0, 1'b1, 8'h77, 2'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
